// File: rtl/result_arbiter_if.sv
// Result bus between the functional-unit senders, the arbiter and the ResultQueue.
interface result_arbiter_if #(
  parameter int unsigned N_REQ = 5,
  parameter int unsigned MSG_W = 32
);
  logic [N_REQ-1:0]            req_en;
  logic [N_REQ-1:0][MSG_W-1:0] req_msg;
  logic [N_REQ-1:0]            req_reject;
  logic                        out_en;
  logic [MSG_W-1:0]            out_msg;
  logic                        out_reject;

  // Arbiter side: consumes requests, produces the registered result.
  modport slave (
    input  req_en, req_msg, out_reject,
    output req_reject, out_en, out_msg
  );

  // Environment side: senders plus the ResultQueue receiver.
  modport master (
    output req_en, req_msg, out_reject,
    input  req_reject, out_en, out_msg
  );
endinterface

// File: rtl/result_arbiter.sv
// Round-robin arbiter sharing one result path into the ResultQueue,
// with a single registered output slot using the en/msg/reject handshake.
module result_arbiter #(
  parameter int unsigned N_REQ = 5,
  parameter int unsigned MSG_W = 32
) (
  input logic              i_clock,
  input logic              i_reset,
  input logic              i_flash,
  result_arbiter_if.slave  io_bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic             r_slot_v;
  logic [MSG_W-1:0] r_slot_msg;
  logic [PTR_W-1:0] r_rr_ptr;

  logic             w_can_load;
  logic             w_any;
  logic [PTR_W-1:0] w_grant;
  logic [PTR_W-1:0] w_idx;
  int unsigned      w_sum;
  logic             w_xfer;

  // Slot can accept when empty or when it is draining this cycle.
  assign w_can_load = ~r_slot_v | ~io_bus.out_reject;
  assign w_xfer     = w_can_load & w_any & ~i_flash & ~i_reset;

  // First requester found scanning from rr_ptr upward with wrap.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = 0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_sum = 32'(r_rr_ptr) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end
      w_idx = PTR_W'(w_sum);
      if (!w_any && io_bus.req_en[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Only the granted requester sees reject low, and never during flush or reset.
  always_comb begin
    io_bus.req_reject = '1;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      io_bus.req_reject[i] = ~(w_can_load & w_any & (w_grant == PTR_W'(i)))
                             | i_flash | i_reset;
    end
  end

  // A flushed result must not reach the ResultQueue in the flush cycle.
  assign io_bus.out_en  = r_slot_v & ~i_flash;
  assign io_bus.out_msg = r_slot_msg;

  // Output slot and round-robin pointer; reset dominates flash.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_slot_v <= 1'b0;
      r_rr_ptr <= '0;
    end else if (i_flash) begin
      r_slot_v <= 1'b0;
    end else if (w_xfer) begin
      r_slot_v   <= 1'b1;
      r_slot_msg <= io_bus.req_msg[w_grant];
      r_rr_ptr   <= (w_grant == LAST_IDX) ? '0 : w_grant + PTR_W'(1);
    end else if (r_slot_v && !io_bus.out_reject) begin
      r_slot_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_arbiter.sv
// Self-checking bench for result_arbiter: directed scenarios plus random
// traffic, all compared against a queue-level behavioural model.
module tb_result_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned MW = 8;

  logic clk;
  logic rst;
  logic fl;

  result_arbiter_if #(.N_REQ(N), .MSG_W(MW)) bus ();

  result_arbiter #(.N_REQ(N), .MSG_W(MW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_flash (fl),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_err;

  // Model state: one-entry slot plus priority index.
  bit          m_v;
  logic [MW-1:0] m_msg;
  int          m_ptr;
  int          m_g;
  bit          m_can;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (bus.req_en[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] en, input logic orej, input logic f, input logic r);
    bus.req_en     = en;
    bus.out_reject = orej;
    fl             = f;
    rst            = r;
  endtask

  // Compare all DUT outputs against the model mid-cycle.
  task automatic settle();
    logic [N-1:0] exp_rej;
    @(negedge clk);
    m_g   = model_grant();
    m_can = !m_v || !bus.out_reject;
    exp_rej = '1;
    if (m_can && m_g >= 0 && !fl && !rst) exp_rej[m_g] = 1'b0;
    chk("req_reject", 32'(bus.req_reject), 32'(exp_rej));
    chk("out_en", 32'(bus.out_en), 32'(m_v && !fl));
    if (m_v && !fl) chk("out_msg", 32'(bus.out_msg), 32'(m_msg));
  endtask

  // Clock edge: apply the handshake rules to the model.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_ptr = 0;
    end else if (fl) begin
      m_v = 0;
    end else if (m_can && m_g >= 0) begin
      m_v = 1; m_msg = bus.req_msg[m_g]; m_ptr = (m_g + 1) % N;
    end else if (m_v && !bus.out_reject) begin
      m_v = 0;
    end
    #1;
  endtask

  logic [N-1:0] e;
  logic [N-1:0] prev_en;
  logic [N-1:0] prev_rej;

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_v = 0; m_ptr = 0; m_msg = '0;
    for (int i = 0; i < N; i++) bus.req_msg[i] = MW'(8'h10 + i);
    drive('1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset holds everything rejected and the output empty.
    settle();
    chk("rst_out_en", 32'(bus.out_en), 32'h0);
    chk("rst_rej", 32'(bus.req_reject), 32'h1f);
    advance();

    // Idle.
    drive('0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("idle_rej", 32'(bus.req_reject), 32'h1f);
    advance();

    // Single request on 2.
    bus.req_msg[2] = 8'hA5;
    drive(5'b00100, 1'b0, 1'b0, 1'b0);
    settle();
    chk("a5_rej", 32'(bus.req_reject), 32'h1b);
    advance();
    drive('0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("a5_out_en", 32'(bus.out_en), 32'h1);
    chk("a5_out_msg", 32'(bus.out_msg), 32'ha5);
    // rr_ptr is 3: a full request set grants 3.
    drive('1, 1'b1, 1'b0, 1'b0);
    bus.out_reject = 1'b0;
    bus.req_en     = '0;
    advance();
    drive('1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("ptr3_rej", 32'(bus.req_reject), 32'h17);
    drive('0, 1'b0, 1'b0, 1'b1);
    advance();
    settle();
    advance();

    // All five requesting from pointer 0.
    for (int i = 0; i < N; i++) bus.req_msg[i] = MW'(8'h10 + i);
    for (int c = 0; c < 10; c++) begin
      drive('1, 1'b0, 1'b0, 1'b0);
      settle();
      e = '1;
      e[c % N] = 1'b0;
      chk("rr_rej", 32'(bus.req_reject), 32'(e));
      if (c > 0) begin
        chk("rr_out_en", 32'(bus.out_en), 32'h1);
        chk("rr_out_msg", 32'(bus.out_msg), 32'(8'h10 + ((c - 1) % N)));
      end
      advance();
    end

    // Backpressure holds the slot and rejects everyone.
    for (int c = 0; c < 3; c++) begin
      drive(5'b01001, 1'b1, 1'b0, 1'b0);
      settle();
      chk("bp_rej", 32'(bus.req_reject), 32'h1f);
      chk("bp_out_msg", 32'(bus.out_msg), 32'h14);
      advance();
    end
    drive(5'b01001, 1'b0, 1'b0, 1'b0);
    settle();
    chk("bp_release_rej", 32'(bus.req_reject), 32'h1e);
    advance();

    // Walk pointer to 4, then show wrap.
    drive(5'b01000, 1'b0, 1'b0, 1'b0);
    settle();
    chk("nobubble_msg", 32'(bus.out_msg), 32'h10);
    chk("to4_rej", 32'(bus.req_reject), 32'h17);
    advance();
    drive(5'b10010, 1'b0, 1'b0, 1'b0);
    settle();
    chk("wrap4_rej", 32'(bus.req_reject), 32'h0f);
    advance();
    drive(5'b10010, 1'b0, 1'b0, 1'b0);
    settle();
    chk("wrap1_rej", 32'(bus.req_reject), 32'h1d);
    chk("wrap_out_msg", 32'(bus.out_msg), 32'h14);
    advance();

    // Flush with a full slot and a pending request.
    drive(5'b00010, 1'b0, 1'b1, 1'b0);
    settle();
    chk("fl_out_en", 32'(bus.out_en), 32'h0);
    chk("fl_rej", 32'(bus.req_reject), 32'h1f);
    advance();
    drive(5'b00010, 1'b0, 1'b0, 1'b0);
    settle();
    chk("post_fl_out_en", 32'(bus.out_en), 32'h0);
    chk("post_fl_rej", 32'(bus.req_reject), 32'h1d);
    advance();

    // Reset and flush together mid-stream.
    drive('1, 1'b0, 1'b1, 1'b1);
    settle();
    chk("rf_rej", 32'(bus.req_reject), 32'h1f);
    advance();
    drive(5'b00101, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rf_grant0_rej", 32'(bus.req_reject), 32'h1e);
    advance();
    drive('0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rf_out_msg", 32'(bus.out_msg), 32'h10);
    advance();

    // Random traffic; a rejected sender keeps its payload.
    prev_en  = '0;
    prev_rej = '1;
    for (int c = 0; c < 3000; c++) begin
      e = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!(prev_en[i] && prev_rej[i] && e[i])) bus.req_msg[i] = MW'($urandom);
      end
      drive(e, ($urandom % 10) < 3, ($urandom % 40) == 0, ($urandom % 100) == 0);
      settle();
      prev_en  = bus.req_en;
      prev_rej = bus.req_reject;
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
